// File: rtl/ifft_pkg.sv
// ifft_pkg: shared sizes, FSM state type and output scaling helper for the IFFT controller.
package ifft_pkg;
    localparam int WORD_W   = 17;
    localparam int N_WORDS  = 16;
    localparam int LATENCY  = 3;
    localparam int CNT_W    = $clog2(N_WORDS);
    localparam int SCALE_SH = $clog2(N_WORDS / 2);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPTURE, UNLOAD} ctrl_state_t;

    // Arithmetic shift floors toward -inf, giving the 1/N normalisation.
    function automatic logic [WORD_W-1:0] scale_word(input logic [WORD_W-1:0] w);
        return WORD_W'($signed(w) >>> SCALE_SH);
    endfunction
endpackage

// File: rtl/ifft_out_stream.sv
// ifft_out_stream: result buffer and valid/ready output streamer for the IFFT controller.
// Defining IFFT_SCALE_EN right-shifts every output word by log2(N_WORDS/2).
module ifft_out_stream
    import ifft_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      capture,
    input  logic [N_WORDS*WORD_W-1:0] res_bus,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WORD_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      fin
);
    logic [WORD_W-1:0] res_q [N_WORDS];
    logic [WORD_W-1:0] res_d [N_WORDS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] word;

    always_comb begin
        res_d   = res_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        fin     = 1'b0;
        if (capture) begin
            for (int k = 0; k < N_WORDS; k++) res_d[k] = res_bus[k*WORD_W +: WORD_W];
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            fin     = cnt_q == CNT_W'(N_WORDS - 1);
            valid_d = !fin;
            cnt_d   = fin ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '{default: '0};
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign word      = res_q[cnt_q];
    assign out_valid = valid_q;
    assign out_last  = valid_q && cnt_q == CNT_W'(N_WORDS - 1);
`ifdef IFFT_SCALE_EN
    assign out_data  = valid_q ? scale_word(word) : '0;
`else
    assign out_data  = valid_q ? word : '0;
`endif
endmodule

// File: rtl/ifft_ctrl.sv
// ifft_ctrl: loads 16 words serially onto the IFFT sample bus, waits out the pipeline,
// captures the result bus and streams it back out. Optional IFFT_SCALE_EN scales outputs by 1/8.
module ifft_ctrl
    import ifft_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [WORD_W-1:0]         in_data,
    output logic                      in_ready,
    output logic [N_WORDS*WORD_W-1:0] smp_bus,
    input  logic [N_WORDS*WORD_W-1:0] res_bus,
    output logic                      out_valid,
    output logic [WORD_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);
    localparam int LAT_W = $clog2(LATENCY + 1);

    ctrl_state_t               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic [N_WORDS*WORD_W-1:0] smp_q, smp_d;
    logic                      done_q, done_d;
    logic                      capture;
    logic                      fin;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        smp_d   = smp_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: if (in_valid) begin
                smp_d[cnt_q*WORD_W +: WORD_W] = in_data;
                // Counter parks on the last index; the state change ends the load.
                if (cnt_q == CNT_W'(N_WORDS - 1)) begin
                    state_d = WAIT;
                    lat_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                state_d = lat_q == LAT_W'(LATENCY - 1) ? CAPTURE : WAIT;
                lat_d   = lat_q == LAT_W'(LATENCY - 1) ? '0 : lat_q + 1'b1;
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = UNLOAD;
            end
            UNLOAD: if (fin) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            smp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            smp_q   <= smp_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = state_q == LOAD;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign smp_bus  = smp_q;

    ifft_out_stream u_out (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .res_bus   (res_bus),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .fin       (fin)
    );
endmodule

// File: tb/tb_ifft_ctrl.sv
// tb_ifft_ctrl: directed self-checking bench for ifft_ctrl with a 3-stage stub datapath.
module tb_ifft_ctrl;
    import ifft_pkg::*;
    localparam int BW = N_WORDS * WORD_W;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, out_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_ready, out_valid, out_last, busy, done;
    logic [WORD_W-1:0] out_data;
    logic [BW-1:0]     smp_bus, res_bus;
    logic [BW-1:0]     p1 = '0, p2 = '0, p3 = '0;
    logic [WORD_W-1:0] off = '0;
    logic [WORD_W-1:0] din_a [N_WORDS];
    logic [WORD_W-1:0] exp_a [N_WORDS];
    int n_tests = 0, n_fail = 0, cyc = 0, t_done = 0;

    ifft_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .smp_bus(smp_bus), .res_bus(res_bus), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BW-1:0] stub(input logic [BW-1:0] s, input logic [WORD_W-1:0] o);
        logic [BW-1:0] r;
        for (int k = 0; k < N_WORDS; k++) r[k*WORD_W +: WORD_W] = s[k*WORD_W +: WORD_W] + o;
        return r;
    endfunction

    // Stub datapath: one register per butterfly stage.
    always @(posedge clk) begin
        p1 <= stub(smp_bus, off);
        p2 <= p1;
        p3 <= p2;
    end
    assign res_bus = p3;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {in_ready, out_valid, out_last, busy, done}, '0);
        chk({tag, "_smp"}, smp_bus, '0);
        chk({tag, "_out"}, out_data, '0);
    endtask

    task automatic run_xfer(input string tag, input int gap, input int rdy_mode, input bit hold, input bit b2b);
        int acc = 0, oidx = 0, t_acc = -1000, t_ov = -1, t_last = -1000, first_rdy = -1, k = 0;
        int prev_done = t_done;
        bit seen_done = 0, pv = 0, pr = 0, pl = 0;
        logic [WORD_W-1:0] pd = '0;
        logic [BW-1:0] exp_bus;
        for (int i = 0; i < N_WORDS; i++) exp_bus[i*WORD_W +: WORD_W] = din_a[i];
        while (!seen_done && k < 600) begin
            @(negedge clk);
            start     = hold || k == 0;
            in_valid  = acc < N_WORDS ? k % gap == 0 : 1'b1;
            in_data   = acc < N_WORDS ? din_a[acc & (N_WORDS - 1)] : 17'h0AAAA;
            out_ready = rdy_mode == 0 || k % 3 == 0;
            #1;
            if (in_ready && first_rdy < 0) first_rdy = cyc;
            if (in_valid && in_ready) begin
                acc++;
                if (acc == N_WORDS) t_acc = cyc;
            end
            if (out_valid) begin
                if (t_ov < 0) begin
                    t_ov = cyc;
                    chk({tag, "_smp_bus"}, smp_bus, exp_bus);
                end
                if (pv && !pr) begin
                    chk({tag, "_hold_data"}, out_data, pd);
                    chk({tag, "_hold_last"}, out_last, pl);
                end
                if (out_ready && oidx < N_WORDS) begin
                    chk($sformatf("%s_word%0d", tag, oidx), out_data, exp_a[oidx]);
                    chk($sformatf("%s_last%0d", tag, oidx), out_last, oidx == N_WORDS - 1);
                    oidx++;
                    if (oidx == N_WORDS) t_last = cyc;
                end
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pl = out_last;
            if (done) begin
                seen_done = 1;
                t_done = cyc;
            end
            k++;
        end
        chk({tag, "_done_seen"}, seen_done, 1);
        chk({tag, "_accepts"}, acc, N_WORDS);
        chk({tag, "_outputs"}, oidx, N_WORDS);
        chk({tag, "_latency"}, t_ov - t_acc, 5);
        chk({tag, "_done_delay"}, t_done - t_last, 1);
        if (b2b) chk({tag, "_b2b_load"}, first_rdy, prev_done + 1);
        if (!hold) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            #1;
            chk({tag, "_idle_after"}, {busy, done, in_ready, out_valid}, '0);
        end
    endtask

    initial begin
        int acc, dcount;
        reset = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 17'h1234; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic: 1..16 in, datapath adds 99 -> 100..115 out.
        off = 17'd99;
        for (int i = 0; i < N_WORDS; i++) begin din_a[i] = 17'(i + 1); exp_a[i] = 17'(100 + i); end
        run_xfer("basic", 1, 0, 0, 0);

        // Backpressure: out_ready 1,0,0 repeating.
        off = 17'd5;
        for (int i = 0; i < N_WORDS; i++) begin din_a[i] = 17'(17'h01000 + 7 * i); exp_a[i] = 17'(17'h01005 + 7 * i); end
        run_xfer("bp", 1, 1, 0, 0);

        // Input gaps: in_valid every third cycle.
        off = '0;
        for (int i = 0; i < N_WORDS; i++) begin din_a[i] = 17'h15555 ^ 17'(i); exp_a[i] = din_a[i]; end
        run_xfer("gap", 3, 0, 0, 0);

        // Reset after 7 accepted words.
        acc = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 50 && acc < 7; k++) begin
            in_valid = 1'b1;
            in_data  = 17'(17'h00300 + acc);
            #1;
            if (in_ready) acc++;
            @(negedge clk);
            start = 1'b0;
        end
        chk("midrst_fed", acc, 7);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_reset_vals("midrst");
        reset = 1'b0;
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (done || busy) dcount++;
        end
        chk("midrst_no_done", dcount, 0);
        off = '0;
        for (int i = 0; i < N_WORDS; i++) begin din_a[i] = 17'(17'h1FFFF - i); exp_a[i] = din_a[i]; end
        run_xfer("after_rst", 1, 0, 0, 0);

        // Scaling: +16 / -16 alternating.
        off = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            din_a[i] = i[0] ? 17'h1FFF0 : 17'h00010;
`ifdef IFFT_SCALE_EN
            exp_a[i] = i[0] ? 17'h1FFFE : 17'h00002;
`else
            exp_a[i] = din_a[i];
`endif
        end
        run_xfer("scale", 1, 0, 0, 0);

        // Back-to-back with start held high and stray in_valid outside LOAD.
        off = 17'd3;
        for (int i = 0; i < N_WORDS; i++) begin din_a[i] = 17'(17'h00A00 + 3 * i); exp_a[i] = 17'(17'h00A03 + 3 * i); end
        run_xfer("b2b_a", 1, 0, 1, 0);
        for (int i = 0; i < N_WORDS; i++) begin din_a[i] = 17'(17'h10000 + 5 * i); exp_a[i] = 17'(17'h10003 + 5 * i); end
        run_xfer("b2b_b", 1, 0, 1, 1);
        start = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ifft_ctrl.md
Name: ifft_ctrl

Overview:
- Sequencing controller for the 8-point complex IFFT datapath (16 x 17-bit words, interleaved real/imag).
- Accepts words serially over a valid/ready stream and assembles them into the parallel sample bus.
- Waits out the butterfly pipeline latency, captures the parallel result bus, then streams the 16 results out over a valid/ready stream.
- Provides the real done/busy status that the datapath itself does not generate.

Parameters:
- WORD_W, 17, width of one sample/result word.
- N_WORDS, 16, words per transform (8 complex points x re/im).
- LATENCY, 3, clock cycles from a stable sample bus to a valid result bus (one per butterfly stage).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a transform; sampled only in IDLE.
- in_valid  in  1  input word valid.
- in_data  in  WORD_W  input word.
- in_ready  out  1  controller accepts in_data this cycle.
- smp_bus  out  N_WORDS*WORD_W  to datapath; word k occupies bits [k*WORD_W +: WORD_W], k=0 is sample1.
- res_bus  in  N_WORDS*WORD_W  from datapath; word k in the same packing, k=0 is a2 ... k=15 is p2.
- out_valid  out  1  output word valid.
- out_data  out  WORD_W  output word.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  high with out_valid on word 15.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE.
  - in_ready, out_valid, out_last, busy, done = 0.
  - smp_bus, out_data = 0; the word counter and the latency counter = 0.
- States:
  - IDLE: start=1 -> LOAD, word counter cleared.
  - LOAD:
    - in_ready=1.
    - Each in_valid&&in_ready writes in_data into smp_bus word[cnt] and increments cnt.
    - The handshake on cnt=15 -> WAIT, in_ready=0 from the next cycle.
  - WAIT:
    - smp_bus held stable; the latency counter counts LATENCY cycles.
    - When the count expires -> CAPTURE.
  - CAPTURE:
    - One cycle: register res_bus into the internal result buffer.
    - -> UNLOAD with cnt=0.
  - UNLOAD:
    - out_valid=1 and out_data=result[cnt].
    - Advance on out_valid&&out_ready.
    - out_last=1 when cnt=15.
    - The handshake on cnt=15 -> IDLE with done=1 for exactly that next cycle.
- Timing:
  - The final input word is accepted at edge t. smp_bus is complete from t+1.
  - res_bus is sampled at edge t+1+LATENCY. The first out_valid is visible at t+2+LATENCY.
  - The output stream is zero-bubble when out_ready is held high: 16 words in 16 cycles.
- Backpressure:
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - Input gaps (in_valid=0) stall LOAD indefinitely with no timeout.
- Simultaneous events and boundaries:
  - start outside IDLE is ignored.
  - start in the done cycle (state already IDLE) is accepted, giving back-to-back transforms.
  - in_valid outside LOAD is ignored (in_ready=0).
  - res_bus is ignored except in CAPTURE.
  - reset mid-transform aborts immediately: partial data is discarded, no done pulse, outputs take their reset values.
  - The counters never wrap: the counter saturates at N_WORDS-1 and the state changes on that handshake.
- Arithmetic: words are passed unmodified; the controller has no arithmetic except under the optional feature.

Optional Feature:
- IFFT_SCALE_EN defined: each output word is arithmetically right-shifted by log2(N_WORDS/2)=3 (sign-extended, truncation toward -inf), giving 1/N IFFT normalisation. Latency is unchanged.
- IFFT_SCALE_EN undefined: output words equal the captured res_bus words bit-exactly.

Decomposition:
- Package ifft_pkg holds:
  - WORD_W, N_WORDS and LATENCY defaults.
  - The state enum ctrl_state_t {IDLE, LOAD, WAIT, CAPTURE, UNLOAD}.
  - The derived CNT_W = $clog2(N_WORDS) and the scale shift constant.
- One natural sub-module: ifft_out_stream (result buffer, output counter, valid/ready/last logic, optional scaling).
- The FSM, input assembly and latency counter stay in ifft_ctrl.

Test Plan:
- Basic:
  - Stimulus: reset, start=1, feed words 1..16 with in_valid held high; stub datapath returns res word k = 100+k after 3 cycles; out_ready=1.
  - Required: smp_bus word k = k+1; outputs 100..115 on consecutive cycles; out_last on 115; done one cycle after; first out_valid 5 cycles after the last input accept.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,... during UNLOAD.
  - Required: each word held through its stall cycles; no word lost or duplicated; exactly 16 handshakes, then done.
- Input gaps:
  - Stimulus: in_valid high every third cycle.
  - Required: exactly 16 words accepted in order; WAIT entered only after the 16th; smp_bus correct.
- Reset mid-operation:
  - Stimulus: assert reset after 7 input words, then run a full transform with words 0x1FFFF down to 0x1FFF0.
  - Required: outputs at reset values, no done for the aborted run; second transform correct.
- Back-to-back and ignored events:
  - Stimulus: start held high continuously; stray in_valid during WAIT/UNLOAD.
  - Required: second transform begins in the done cycle; stray words ignored.
- IFFT_SCALE_EN:
  - Stimulus: res words 0x00010 and 0x1FFF0 (-16).
  - Required: outputs 0x00002 and 0x1FFFE (-2); without the macro, 0x00010 and 0x1FFF0.
